// File: rtl/mycpu_pkg.sv
// Shared types for the mycpu control unit: FU function codes, instruction
// classes, branch conditions, controller states and the decoded control word.
package mycpu_pkg;

  typedef enum logic [3:0] {
    MOVA  = 4'd0,
    FINC  = 4'd1,
    FADD  = 4'd2,
    FSUB  = 4'd3,
    FDEC  = 4'd4,
    FAND  = 4'd5,
    FOR   = 4'd6,
    FXOR  = 4'd7,
    FNOT  = 4'd8,
    FMOVB = 4'd9,
    FSHR  = 4'd10,
    FSHL  = 4'd11,
    FCLR  = 4'd12,
    FMUL  = 4'd13
  } fs_t;

  typedef enum logic [2:0] {
    ClsAluReg  = 3'd0,
    ClsAluImm  = 3'd1,
    ClsLd      = 3'd2,
    ClsSt      = 3'd3,
    ClsBr      = 3'd4,
    ClsJmp     = 3'd5,
    ClsIllegal = 3'd6,
    ClsHalt    = 3'd7
  } class_t;

  typedef enum logic [3:0] {
    CondAlways = 4'd0,
    CondZ      = 4'd1,
    CondN      = 4'd2,
    CondNz     = 4'd3,
    CondNn     = 4'd4
  } cond_t;

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExec,
    StMem,
    StHalt
  } ctrl_state_t;

  // Controls asserted during EXEC, plus register addresses and immediate.
  typedef struct packed {
    fs_t         fs;
    logic        rf_we;
    logic        mb_sel;
    logic        dmem_we;
    logic        flags_we;
    logic        is_ld;
    logic [2:0]  da;
    logic [2:0]  aa;
    logic [2:0]  ba;
    logic [15:0] konst;
  } ctrl_word_t;

  // Branch condition evaluation against the latched flags.
  function automatic logic cond_met(input logic [3:0] cond, input logic zf, input logic nf);
    case (cond)
      CondAlways: cond_met = 1'b1;
      CondZ:      cond_met = zf;
      CondN:      cond_met = nf;
      CondNz:     cond_met = ~zf;
      CondNn:     cond_met = ~nf;
      default:    cond_met = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mycpu_decode.sv
// Combinational instruction decoder: maps an instruction word to its class,
// the EXEC-phase control word and the illegal/halt indications.
module mycpu_decode
  import mycpu_pkg::*;
(
  input  logic [15:0] ir_i,
  output class_t      cls_o,
  output ctrl_word_t  ctrl_o,
  output logic        illegal_o,
  output logic        halt_o
);

  logic [3:0] fn;
  assign fn = ir_i[12:9];

  // Class decode and per-class control generation.
  always_comb begin
    cls_o     = class_t'(ir_i[15:13]);
    ctrl_o    = '{fs: MOVA, default: '0};
    ctrl_o.da = ir_i[8:6];
    ctrl_o.aa = ir_i[5:3];
    ctrl_o.ba = ir_i[2:0];
    ctrl_o.konst = {13'b0, ir_i[2:0]};
    illegal_o = 1'b0;
    halt_o    = 1'b0;
    case (cls_o)
      ClsAluReg, ClsAluImm: begin
        // fn codes above FMUL have no FU function behind them
        if (fn > FMUL) begin
          illegal_o = 1'b1;
        end else begin
          ctrl_o.fs       = fs_t'(fn);
          ctrl_o.rf_we    = 1'b1;
          ctrl_o.mb_sel   = (cls_o == ClsAluImm);
          ctrl_o.flags_we = 1'b1;
        end
      end
      ClsLd:      ctrl_o.is_ld = 1'b1;
      ClsSt:      ctrl_o.dmem_we = 1'b1;
      ClsBr:      illegal_o = (fn > CondNn);
      ClsJmp:     ;
      ClsIllegal: illegal_o = 1'b1;
      ClsHalt:    halt_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/mycpu_ctrl.sv
// Multicycle control unit: FETCH/DECODE/EXEC(/MEM) sequencing, PC, IR and
// the ALU flag register, driving FU and datapath controls.
module mycpu_ctrl
  import mycpu_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run_in,
  output logic [7:0]  imem_addr,
  input  logic [15:0] imem_rdata,
  output logic [3:0]  fs_out,
  output logic [2:0]  da_out,
  output logic [2:0]  aa_out,
  output logic [2:0]  ba_out,
  output logic        rf_we,
  output logic        mb_sel,
  output logic        md_sel,
  output logic [15:0] const_out,
  output logic        dmem_we,
  input  logic        z_in,
  input  logic        n_in,
  output logic        halted,
  output logic        illegal
);

  ctrl_state_t state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic        zf_q, zf_d;
  logic        nf_q, nf_d;
  logic        illegal_q, illegal_d;

  logic [15:0] dec_ir;
  class_t      dec_cls;
  ctrl_word_t  dec_ctrl;
  logic        dec_illegal;
  logic        dec_halt;
  logic [7:0]  pc_inc;
  logic        br_taken;

  // In DECODE the word is still on the memory bus; later states use IR.
  assign dec_ir = (state_q == StDecode) ? imem_rdata : ir_q;

  mycpu_decode u_decode (
    .ir_i      (dec_ir),
    .cls_o     (dec_cls),
    .ctrl_o    (dec_ctrl),
    .illegal_o (dec_illegal),
    .halt_o    (dec_halt)
  );

  assign imem_addr = pc_q;
  assign da_out    = dec_ctrl.da;
  assign aa_out    = dec_ctrl.aa;
  assign ba_out    = dec_ctrl.ba;
  assign const_out = dec_ctrl.konst;
  assign pc_inc    = pc_q + 8'd1;
  assign br_taken  = cond_met(ir_q[12:9], zf_q, nf_q);

  // Next-state, PC/flag update and output decode.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    zf_d      = zf_q;
    nf_d      = nf_q;
    illegal_d = illegal_q;
    fs_out    = MOVA;
    rf_we     = 1'b0;
    mb_sel    = 1'b0;
    md_sel    = 1'b0;
    dmem_we   = 1'b0;
    halted    = 1'b0;
    illegal   = 1'b0;
    case (state_q)
      StFetch: begin
        if (run_in) state_d = StDecode;
      end
      StDecode: begin
        ir_d = imem_rdata;
        if (dec_halt || dec_illegal) begin
          state_d   = StHalt;
          illegal_d = dec_illegal;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        fs_out  = dec_ctrl.fs;
        rf_we   = dec_ctrl.rf_we;
        mb_sel  = dec_ctrl.mb_sel;
        dmem_we = dec_ctrl.dmem_we;
        if (dec_ctrl.flags_we) begin
          zf_d = z_in;
          nf_d = n_in;
        end
        // Offset bit 8 drops out: PC arithmetic is modulo 256.
        case (dec_cls)
          ClsBr:   pc_d = br_taken ? pc_inc + ir_q[7:0] : pc_inc;
          ClsJmp:  pc_d = ir_q[7:0];
          default: pc_d = pc_inc;
        endcase
        state_d = dec_ctrl.is_ld ? StMem : StFetch;
      end
      StMem: begin
        rf_we   = 1'b1;
        md_sel  = 1'b1;
        state_d = StFetch;
      end
      StHalt: begin
        halted  = 1'b1;
        illegal = illegal_q;
      end
      default: state_d = StFetch;
    endcase
  end

  // State, PC, IR and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StFetch;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      zf_q      <= 1'b0;
      nf_q      <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      zf_q      <= zf_d;
      nf_q      <= nf_d;
      illegal_q <= illegal_d;
    end
  end

endmodule

// File: tb/tb_mycpu_ctrl.sv
// Bench for mycpu_ctrl: directed instruction sequence plus random
// instructions, checked against an instruction-level reference model.
module tb_mycpu_ctrl;
  import mycpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run_in;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic [3:0]  fs_out;
  logic [2:0]  da_out, aa_out, ba_out;
  logic        rf_we, mb_sel, md_sel, dmem_we;
  logic [15:0] const_out;
  logic        z_in, n_in;
  logic        halted, illegal;

  int tests = 0;
  int fails = 0;

  // Reference architectural state
  logic [7:0] pc_m;
  logic       zf_m, nf_m;
  bit         halted_m;

  logic [15:0] mem [256];

  mycpu_ctrl #(.RESET_PC(8'h00)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run_in     (run_in),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .fs_out     (fs_out),
    .da_out     (da_out),
    .aa_out     (aa_out),
    .ba_out     (ba_out),
    .rf_we      (rf_we),
    .mb_sel     (mb_sel),
    .md_sel     (md_sel),
    .const_out  (const_out),
    .dmem_we    (dmem_we),
    .z_in       (z_in),
    .n_in       (n_in),
    .halted     (halted),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory
  always @(posedge clk) imem_rdata <= mem[imem_addr];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " imem_addr"}, {8'h00, imem_addr}, 16'h0000);
    chk({tag, " fs_out"}, {12'h0, fs_out}, {12'h0, 4'(MOVA)});
    chk({tag, " strobes"}, {12'h0, rf_we, mb_sel, md_sel, dmem_we}, 16'h0000);
    chk({tag, " halted/illegal"}, {14'h0, halted, illegal}, 16'h0000);
    chk({tag, " const_out"}, const_out, 16'h0000);
    chk({tag, " addrs"}, {7'h0, da_out, aa_out, ba_out}, 16'h0000);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    run_in = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    pc_m = 8'h00;
    zf_m = 1'b0;
    nf_m = 1'b0;
    halted_m = 1'b0;
  endtask

  // Execute one instruction at the model PC, starting at a FETCH sample point.
  task automatic exec_instr(input logic [15:0] w, input logic z, input logic n,
                            input bit drop_run);
    logic [2:0] cls;
    logic [3:0] fn;
    bit bad, stop, is_alu, is_ld, is_st, taken;
    int off, len, t;
    cls = w[15:13];
    fn = w[12:9];
    bad = (cls == 3'd6) || (cls <= 3'd1 && fn >= 4'd14) || (cls == 3'd4 && fn > 4'd4);
    stop = bad || (cls == 3'd7);
    is_alu = (cls <= 3'd1) && !bad;
    is_ld = (cls == 3'd2);
    is_st = (cls == 3'd3);
    mem[pc_m] = w;
    z_in = z;
    n_in = n;
    len = stop ? 2 : (is_ld ? 4 : 3);
    for (int c = 1; c <= len; c++) begin
      if (c <= 2) chk("imem_addr", {8'h00, imem_addr}, {8'h00, pc_m});
      chk("rf_we", {15'h0, rf_we}, {15'h0, (c == 3 && is_alu) || (c == 4 && is_ld)});
      chk("dmem_we", {15'h0, dmem_we}, {15'h0, c == 3 && is_st});
      chk("mb_sel", {15'h0, mb_sel}, {15'h0, c == 3 && is_alu && cls == 3'd1});
      chk("md_sel", {15'h0, md_sel}, {15'h0, c == 4 && is_ld});
      chk("fs_out", {12'h0, fs_out}, {12'h0, (c == 3 && is_alu) ? fn : 4'(MOVA)});
      chk("halted", {15'h0, halted}, 16'h0000);
      if (c == 3 && (is_alu || is_st)) begin
        chk("aa_out", {13'h0, aa_out}, {13'h0, w[5:3]});
        chk("ba_out", {13'h0, ba_out}, {13'h0, w[2:0]});
      end
      if (c == 3 && is_alu) chk("da_out", {13'h0, da_out}, {13'h0, w[8:6]});
      if (c == 3 && is_alu && cls == 3'd1) chk("const_out", const_out, {13'h0, w[2:0]});
      if (c == 3 && is_ld) chk("ld aa_out", {13'h0, aa_out}, {13'h0, w[5:3]});
      if (c == 4 && is_ld) chk("ld da_out", {13'h0, da_out}, {13'h0, w[8:6]});
      if (c == 2 && drop_run) run_in = 1'b0;
      @(posedge clk);
      #1;
    end
    run_in = 1'b1;
    if (stop) begin
      chk("halt halted", {15'h0, halted}, 16'h0001);
      chk("halt illegal", {15'h0, illegal}, {15'h0, bad});
      chk("halt pc", {8'h00, imem_addr}, {8'h00, pc_m});
      chk("halt strobes", {12'h0, rf_we, mb_sel, md_sel, dmem_we}, 16'h0000);
      chk("halt fs_out", {12'h0, fs_out}, {12'h0, 4'(MOVA)});
      @(posedge clk);
      #1;
      chk("halt sticky", {14'h0, halted, imem_addr == pc_m}, 16'h0003);
      halted_m = 1'b1;
    end else begin
      case (cls)
        3'd4: begin
          case (fn)
            4'd0:    taken = 1'b1;
            4'd1:    taken = zf_m;
            4'd2:    taken = nf_m;
            4'd3:    taken = !zf_m;
            default: taken = !nf_m;
          endcase
          off = int'(w[8:0]) - (w[8] ? 512 : 0);
          t = int'(pc_m) + 1 + (taken ? off : 0);
          while (t < 0) t += 256;
          pc_m = 8'(t % 256);
        end
        3'd5: pc_m = w[7:0];
        default: pc_m = 8'((int'(pc_m) + 1) % 256);
      endcase
      if (is_alu) begin
        zf_m = z;
        nf_m = n;
      end
      chk("next pc", {8'h00, imem_addr}, {8'h00, pc_m});
      chk("not halted", {14'h0, halted, illegal}, 16'h0000);
    end
  endtask

  initial begin
    logic [2:0]  rcls;
    logic [3:0]  rfn;
    logic [15:0] rw;
    rst_n = 1'b0;
    run_in = 1'b1;
    z_in = 1'b0;
    n_in = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 16'hE000;
    @(posedge clk);
    do_reset();
    chk_idle_outputs("reset");

    // ADD r1 <- r2 + r3 at PC 0
    exec_instr({3'b000, 4'(FADD), 3'd1, 3'd2, 3'd3}, 1'b0, 1'b0, 1'b0);
    exec_instr({3'b101, 5'd0, 8'h04}, 1'b0, 1'b0, 1'b0);
    // FSUB imm sets Z, BR Z -2 at PC 5 goes back to 4
    exec_instr({3'b001, 4'(FSUB), 3'd1, 3'd1, 3'd1}, 1'b1, 1'b0, 1'b0);
    exec_instr({3'b100, 4'(CondZ), 9'h1FE}, 1'b0, 1'b1, 1'b0);
    chk("br taken pc", {8'h00, imem_addr}, 16'h0004);
    exec_instr({3'b001, 4'(FSUB), 3'd1, 3'd1, 3'd1}, 1'b0, 1'b0, 1'b0);
    exec_instr({3'b100, 4'(CondZ), 9'h1FE}, 1'b1, 1'b0, 1'b0);
    chk("br not taken pc", {8'h00, imem_addr}, 16'h0006);
    // BR always +3 from 8'hFE wraps to 8'h02
    exec_instr({3'b101, 5'd0, 8'hFE}, 1'b0, 1'b0, 1'b0);
    exec_instr({3'b100, 4'(CondAlways), 9'h003}, 1'b0, 1'b0, 1'b0);
    chk("br wrap pc", {8'h00, imem_addr}, 16'h0002);
    exec_instr({3'b010, 4'd0, 3'd4, 3'd5, 3'd0}, 1'b1, 1'b1, 1'b0);
    exec_instr({3'b011, 4'd0, 3'd0, 3'd6, 3'd7}, 1'b0, 1'b1, 1'b0);

    // run_in low in FETCH holds PC
    run_in = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      chk("stall pc", {8'h00, imem_addr}, {8'h00, pc_m});
      chk("stall strobes", {14'h0, rf_we, dmem_we}, 16'h0000);
    end
    run_in = 1'b1;
    exec_instr({3'b000, 4'(FADD), 3'd7, 3'd6, 3'd5}, 1'b0, 1'b0, 1'b0);

    // Random instructions, occasionally dropping run_in mid-instruction
    for (int k = 0; k < 80; k++) begin
      rcls = 3'($urandom_range(0, 5));
      rfn = (rcls == 3'd4) ? 4'($urandom_range(0, 5)) : 4'($urandom_range(0, 15));
      rw = {rcls, rfn, 9'($urandom)};
      exec_instr(rw, 1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));
      if (halted_m) do_reset();
    end

    // Reset during the MEM cycle of a load
    mem[pc_m] = {3'b010, 4'd0, 3'd4, 3'd5, 3'd0};
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("ld mem rf_we", {14'h0, rf_we, md_sel}, 16'h0003);
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("mid-ld reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    pc_m = 8'h00;
    zf_m = 1'b0;
    nf_m = 1'b0;
    exec_instr({3'b000, 4'(FINC), 3'd2, 3'd2, 3'd0}, 1'b0, 1'b0, 1'b0);

    // Illegal class, illegal ALU fn, and HALT
    exec_instr({3'b110, 13'h0}, 1'b0, 1'b0, 1'b0);
    do_reset();
    exec_instr({3'b000, 4'hF, 9'h0}, 1'b0, 1'b0, 1'b0);
    do_reset();
    exec_instr({3'b111, 13'h0}, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mycpu_ctrl.md
# mycpu_ctrl

Multicycle control unit for the mycpu datapath. It fetches 16-bit instructions from a synchronous instruction memory and decodes them. It drives function-select codes and register-file and memory controls toward the FU and datapath. It consumes the FU zero/negative flags to resolve conditional branches. It sits between the instruction memory and the datapath; the FU is its downstream consumer.

## Interface
- RESET_PC, 8'h00, PC value loaded on reset
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- run_in  in  1  when 0, the unit stalls in FETCH
- imem_addr  out  8  instruction address (the PC)
- imem_rdata  in  16  instruction word, valid the cycle after imem_addr is presented
- fs_out  out  4  function select to FU (mycpu_pkg fs_t encoding)
- da_out / aa_out / ba_out  out  3 each  register destination / A / B addresses
- rf_we  out  1  register-file write enable
- mb_sel  out  1  1: B operand is const_out
- md_sel  out  1  1: register write data from data memory, 0: from FU
- const_out  out  16  zero-extended immediate
- dmem_we  out  1  data-memory write strobe
- z_in / n_in  in  1 each  FU zero / negative flags
- halted  out  1  high in HALT
- illegal  out  1  high in HALT when the halt was caused by an illegal instruction

## Operation
- Instruction word fields: class [15:13], fn [12:9], dr [8:6], sa [5:3], sb [2:0].
- Class encodings:
  - 000 ALU reg: R[dr] <- FU(fn, R[sa], R[sb]).
  - 001 ALU imm: same as ALU reg, with B = {13'b0, sb}.
  - 010 LD: R[dr] <- M[R[sa]].
  - 011 ST: M[R[sa]] <- R[sb].
  - 100 BR: the condition is fn; the offset is the signed 9-bit value [8:0].
  - 101 JMP: PC <- [7:0].
  - 110 illegal.
  - 111 HALT.
- Branch conditions:
  - 0000 always, 0001 Z, 0010 N, 0011 !Z, 0100 !N.
  - Any other condition code is illegal.
- Branch target: PC <- PC + 1 + sext(offset), truncated to 8 bits, so it wraps modulo 256.
- Branch not taken, and all other non-jump instructions: PC <- PC + 1, wraps 8'hFF -> 8'h00.
- ALU fn values 14 and 15 (unused fs_t codes) are illegal.
- Flag register: zf and nf are latched from z_in and n_in at the end of EXEC of ALU-class instructions only. LD, ST, BR and JMP leave the flags unchanged.
- FSM states:
  - FETCH: drives imem_addr = PC; goes to DECODE if run_in, otherwise stays in FETCH.
  - DECODE: latches IR from imem_rdata.
  - EXEC: asserts the controls for one cycle. ALU: rf_we=1. ST: dmem_we=1. LD: address phase only. BR/JMP: update PC. Then goes to FETCH, or to MEM for LD.
  - MEM: rf_we=1, md_sel=1. Then goes to FETCH.
  - HALT: terminal; exits only on reset.
- An illegal instruction or HALT goes DECODE -> HALT. No writes occur and the PC is not advanced. illegal=1 only on an illegal instruction.
- Outside EXEC and MEM: rf_we, dmem_we, mb_sel and md_sel are 0, and fs_out = MOVA.

## Timing
- Reset (asynchronous assert, synchronous release): state FETCH, PC = RESET_PC, zf = nf = 0, IR = 0. All outputs 0 except imem_addr = RESET_PC and fs_out = MOVA.
- Reset asserted mid-instruction aborts the instruction immediately; no strobe survives into the reset cycle.
- Latency:
  - ALU, ST, BR and JMP: 3 cycles (FETCH, DECODE, EXEC).
  - LD: 4 cycles.
  - HALT and illegal instructions: HALT is entered 2 cycles after FETCH.
- The write strobes rf_we and dmem_we are exactly one cycle wide.
- A branch evaluates the flags latched before it. An ALU op immediately followed by BR uses that ALU op's flags.
- run_in is sampled only in FETCH. Deasserting it mid-instruction lets the instruction complete.

## Structure
- mycpu_pkg holds the following, and the unit uses the names, never literals:
  - fs_t: MOVA=0, FINC=1, FADD=2, FSUB=3, FDEC=4, FAND=5, FOR=6, FXOR=7, FNOT=8, FMOVB=9, FSHR=10, FSHL=11, FCLR=12, FMUL=13.
  - class_t and cond_t enums.
  - ctrl_state_t.
- A combinational sub-module mycpu_decode takes IR and produces the control word, class and illegal. The top level holds the FSM, PC, IR and flags.

## Test plan
- Reset, then ADD (000, FADD, dr=1, sa=2, sb=3) at PC 0: fs_out = FADD, rf_we = 1 only in cycle 3, da/aa/ba = 1/2/3, PC = 1.
- ALU imm FSUB with z_in = 1, then BR Z offset = -2 at PC 5: branch taken, PC = 4. Repeat with z_in = 0: PC = 6.
- BR always at PC 8'hFE with offset +3: PC = 8'h02 (wrap).
- LD dr=4, sa=5: rf_we/md_sel high in cycle 4 only. ST: dmem_we high in cycle 3 only, rf_we = 0.
- Class 110 and ALU fn = 15: halted = illegal = 1, no strobes, PC unchanged. Opcode 111: halted = 1, illegal = 0.
- run_in = 0 at FETCH holds PC and state. rst_n pulsed low during a LD MEM cycle: rf_we drops immediately and PC = RESET_PC.
